sram_datacache_bwe: RTL
=======================

# sram_datacache_bwe

Parametrised single-port data-cache SRAM: next generation of the team's data-cache array. Adds per-byte write enables, registered read data with a valid strobe, and write-first read-back. A sequential clear engine zeroes the array one word per cycle, on reset and on request, so the array maps onto real SRAM macros instead of a flop reset. Sits between the cache controller and the data-array storage; the controller sees a ready/valid-style access port.

## Interface
Parameters:
- ADDR_WIDTH, 6, word address width.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- MEM_DEPTH, 64, number of words; 1 ≤ MEM_DEPTH ≤ 2^ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = come out of reset ready, contents undefined.

Ports (NB = DATA_WIDTH/8):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  access request, active low.
- wr_n  in  1  0 = write, 1 = read; qualified by cs_n.
- be  in  NB  byte write enables, active high; bit k covers data bits [8k+7:8k]; ignored on reads.
- addr  in  ADDR_WIDTH  word address.
- data_in  in  DATA_WIDTH  write data.
- clr  in  1  single-cycle request to zero the whole array.
- ready  out  1  1 = access port accepts a request this cycle.
- data_out  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle strobe: data_out carries a fresh result.

## Operation
- FSM states IDLE, CLEAR; a sweep counter clr_addr (ADDR_WIDTH bits).
- ready = (state == IDLE). An access is accepted when ready && !cs_n. Requests while ready = 0 are dropped; the controller must hold or retry.
- Accepted write: for every k with be[k] = 1, mem[addr] byte k ← data_in byte k. Other bytes are unchanged. be = 0 is a legal no-op write.
- Accepted read: data_out ← mem[addr] on that edge.
- Write-first: an accepted write also loads data_out with the merged word (old bytes where be = 0, new bytes where be = 1).
- rd_valid = 1 on the cycle after any accepted access, read or write; 0 otherwise. data_out holds its value when there is no accepted access.
- Out-of-range address (addr ≥ MEM_DEPTH): writes are ignored; reads return all-zero with rd_valid = 1.
- IDLE → CLEAR when clr = 1. An access accepted in the same cycle completes normally, then the sweep starts and erases it.
- In CLEAR: each cycle writes mem[clr_addr] ← 0 and increments clr_addr. When clr_addr = MEM_DEPTH-1 is written, the FSM returns to IDLE.
- clr is ignored while already in CLEAR (no restart, no queueing).
- Reset: state ← CLEAR with clr_addr ← 0 if CLEAR_ON_RESET = 1, else IDLE. Reset mid-sweep restarts the sweep from address 0.

## Timing
- Reset values: data_out = 0, rd_valid = 0, ready = 0 if CLEAR_ON_RESET = 1 else 1.
- Read latency is 1 cycle: request at edge N, data_out/rd_valid valid after edge N, sampled at N+1.
- Back-to-back accesses run one per cycle with no bubbles, including write→read of the same address (the read returns the new data).
- Clear sweep: ready falls the cycle after clr is sampled and stays low for exactly MEM_DEPTH cycles. The first accepted access after that sees all-zero contents.
- Post-reset sweep: ready is 0 for exactly MEM_DEPTH cycles after the first cycle with rst = 0.
- No combinational path from any input to any output; ready, data_out and rd_valid all come straight from flops or state decode.

## Test plan
- Reset with defaults: rst for 2 cycles, then release → ready stays 0 for 64 cycles then goes 1. Reads of addresses 0, 31 and 63 return 0x00000000 with rd_valid pulsing one cycle after each request.
- Byte-enable merge: write 0xAABBCCDD to addr 5 with be = 4'b1111, then write 0x11223344 with be = 4'b0101 → write-first data_out = 0xAA22CC44. A later read of addr 5 returns 0xAA22CC44.
- Back-to-back: write 0x12345678 to addr 9, read addr 9 on the very next cycle → data_out = 0x12345678, rd_valid high on both consecutive cycles.
- clr with a simultaneous write: in IDLE, write 0xFFFFFFFF to addr 3 with clr = 1 → write's rd_valid fires, ready low for 64 cycles. A read of addr 3 afterwards returns 0. Requests issued during the sweep produce no rd_valid.
- Reset mid-sweep: assert rst at sweep cycle 20 → the sweep restarts and ready stays low for 64 full cycles after rst is released. With MEM_DEPTH = 48, a write to addr 50 is ignored and a read of addr 50 returns 0.
- CLEAR_ON_RESET = 0, DATA_WIDTH = 64: ready = 1 on the first cycle after reset. A write of 0x0123456789ABCDEF with be = 8'hF0 to a word previously written with all zeros reads back 0x0123456700000000.

Source files
------------

// File: rtl/sram_datacache_bwe.sv
// Single-port data-cache array with per-byte write enables, registered write-first read data
// and a sequential zero-fill engine, so the storage can map onto plain SRAM macros.

module sram_datacache_bwe_chk (
  input logic clk,
  input logic rst,
  input logic cs_n,
  input logic ready,
  input logic rd_valid
);

  // Every accepted access produces exactly one rd_valid strobe on the following cycle.
  a_valid_after_access: assert property (@(posedge clk) (!rst && ready && !cs_n) |=> rd_valid);
  a_no_valid_otherwise: assert property (@(posedge clk) (rst || !ready || cs_n) |=> !rd_valid);

endmodule

module sram_datacache_bwe #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 64,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cs_n,
  input  logic                      wr_n,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      clr,
  output logic                      ready,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      rd_valid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   clr_addr_r;
  logic [DATA_WIDTH-1:0]   mem_r [0:MEM_DEPTH-1];
  logic [DATA_WIDTH-1:0]   data_out_r;
  logic                    rd_valid_r;

  logic                    acc_s;
  logic                    in_range_s;
  logic                    wr_en_s;
  logic                    clr_we_s;
  logic [DATA_WIDTH-1:0]   rd_word_s;
  logic [DATA_WIDTH-1:0]   merged_s;
  logic [DATA_WIDTH-1:0]   next_data_s;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         en
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < NB; k++) begin
      if (en[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Access decode, range check and write-first merge of the addressed word.
  always_comb begin
    acc_s       = 1'b0;
    in_range_s  = 1'b0;
    wr_en_s     = 1'b0;
    clr_we_s    = 1'b0;
    rd_word_s   = '0;
    merged_s    = '0;
    next_data_s = '0;

    acc_s      = (state_r == IDLE) && !cs_n && !rst;
    in_range_s = ({1'b0, addr} < DEPTH_L);
    if (in_range_s) begin
      rd_word_s = mem_r[addr];
    end else begin
      rd_word_s = '0;
    end
    merged_s = merge_bytes(rd_word_s, data_in, be);
    wr_en_s  = acc_s && !wr_n && in_range_s;
    clr_we_s = (state_r == CLEAR) && !rst;

    // Out-of-range accesses never touch storage and always report zero.
    if (!in_range_s) begin
      next_data_s = '0;
    end else if (!wr_n) begin
      next_data_s = merged_s;
    end else begin
      next_data_s = rd_word_s;
    end
  end

  // Storage write port: zero fill during the sweep, controller writes otherwise.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem_r[clr_addr_r] <= '0;
    end else if (wr_en_s) begin
      mem_r[addr] <= merged_s;
    end
  end

  // Sweep FSM and registered read-data/strobe path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_addr_r <= '0;
      data_out_r <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= acc_s;
      if (acc_s) begin
        data_out_r <= next_data_s;
      end
      case (state_r)
        IDLE: begin
          if (clr) begin
            state_r    <= CLEAR;
            clr_addr_r <= '0;
          end
        end
        CLEAR: begin
          if (clr_addr_r == LAST_ADDR) begin
            state_r    <= IDLE;
            clr_addr_r <= '0;
          end else begin
            clr_addr_r <= clr_addr_r + ADDR_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          clr_addr_r <= '0;
        end
      endcase
    end
  end

  assign ready    = (state_r == IDLE);
  assign data_out = data_out_r;
  assign rd_valid = rd_valid_r;

  sram_datacache_bwe_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .cs_n     (cs_n),
    .ready    (ready),
    .rd_valid (rd_valid)
  );

endmodule
